wr_port_arbiter: RTL and testbench
==================================

WR_PORT_ARBITER -- requirements
Module: wr_port_arbiter

Interface
REQ-001 Parameter DATASIZE, default 8: FIFO write-data width in bits.
REQ-002 Parameter NUM_REQ, default 4: number of write requesters, legal range 2..8.
REQ-003 Parameter BURST_LEN, default 4: maximum writes per grant, legal range 1..16.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-006 wrst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester "data available" flag.
REQ-008 req_data  input  NUM_REQ*DATASIZE  per-requester write data; requester i occupies bits [i*DATASIZE +: DATASIZE].
REQ-009 req_ready  output  NUM_REQ  per-requester accept strobe; a beat transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 idata  output  DATASIZE  FIFO write data.
REQ-011 wren  output  1  FIFO write enable.
REQ-012 wr_full  input  1  FIFO full flag.
REQ-013 grant  output  NUM_REQ  one-hot registered grant, all-zero when idle.
REQ-014 wr_count  output  16  total FIFO writes since reset, saturating at 16'hFFFF.

Function
REQ-015 The FSM SHALL have two states: IDLE and BUSY.
REQ-016 In IDLE with any req_valid set, the block SHALL load grant with the first valid requester at or after rr_ptr (wrapping NUM_REQ-1 to 0), clear burst_cnt, and enter BUSY on the next edge; arbitration latency is 1 cycle.
REQ-017 In IDLE, or in IDLE with no req_valid set, wren, req_ready and grant SHALL be 0; idata SHALL be don't-care, driven to 0.
REQ-018 In BUSY with granted index g: wren = req_valid[g] AND NOT wr_full; req_ready[g] = wren; all other req_ready = 0; idata = req_data[g]. These paths are combinational, and a write occurs in the same cycle.
REQ-019 On each write, burst_cnt SHALL increment and wr_count SHALL increment unless it equals 16'hFFFF.
REQ-020 BUSY SHALL return to IDLE on the edge where a write occurs with burst_cnt == BURST_LEN-1.
REQ-021 BUSY SHALL return to IDLE on the edge where req_valid[g] is 0.
REQ-022 On return to IDLE, grant SHALL clear and rr_ptr SHALL become (g+1) mod NUM_REQ.
REQ-023 While wr_full is high in BUSY with req_valid[g] high, the block SHALL hold grant and burst_cnt, and assert no wren; there is no timeout.
REQ-024 wr_full rising in the same cycle that req_valid[g] is high SHALL suppress that write (no wren, no ready).
REQ-025 A requester SHALL NOT receive consecutive grants while another requester is valid in the IDLE cycle (strict round-robin).
REQ-026 At most one req_ready bit SHALL be high in any cycle; wren SHALL never be high while wr_full is high.

Reset
REQ-027 With wrst high at a rising wclk, the block SHALL set state = IDLE, grant = 0, rr_ptr = 0, burst_cnt = 0, wr_count = 0; wren and req_ready are 0 in the following cycle.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no write in the reset cycle, and SHALL take priority over all other events.

Structure
REQ-029 Package wr_arb_pkg SHALL hold: the state enum (IDLE, BUSY), default NUM_REQ/BURST_LEN constants, and the wr_count width constant (16).
REQ-030 Sub-module rr_pick SHALL perform the combinational round-robin selection (inputs: req vector, rr_ptr; outputs: one-hot pick, any).
REQ-031 grant, rr_ptr, burst_cnt, state and wr_count SHALL be flops; all other outputs are combinational from them and the inputs.

Verification
REQ-032 Single requester: req_valid=4'b0010, 6 beats 8'hA0..8'hA5, wr_full=0 -> IDLE 1 cycle, 4 writes A0..A3, IDLE 1 cycle, then 2 writes A4..A5; wr_count=6.
REQ-033 All valid continuously -> grant sequence 0001, 0010, 0100, 1000, 0001, with 4 writes each and 1 idle cycle between grants.
REQ-034 wr_full held high 3 cycles mid-burst at beat 2 -> wren=0 for those 3 cycles, grant and burst_cnt held, burst completes with beats 2..3 afterwards.
REQ-035 Granted requester drops req_valid after 1 beat -> IDLE next edge; rr_ptr advances; another valid requester is granted the following cycle.
REQ-036 wrst pulsed during beat 2 of requester 2's burst -> grant=0, wr_count=0, no wren in the reset cycle; next grant goes to requester 0.
REQ-037 Run 70000 writes -> wr_count stays at 16'hFFFF; checker asserts REQ-026 every cycle.

Source files
------------

// File: rtl/wr_arb_pkg.sv
// rtl/wr_arb_pkg.sv - shared types and constants for the FIFO write-port arbiter
package wr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_LEN = 4;
    localparam int WR_COUNT_W    = 16;
    localparam int BURST_CNT_W   = 5;

endpackage

// File: rtl/wr_port_arbiter_rr_pick.sv
// rtl/wr_port_arbiter_rr_pick.sv - round-robin pick of the first set request at or after ptr
module rr_pick #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          any
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + 32'(i)) % 32'(N));
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/wr_port_arbiter.sv
// rtl/wr_port_arbiter.sv - round-robin arbiter granting bursts of FIFO writes to requesters
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter int DATASIZE  = 8,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BURST_LEN = DEF_BURST_LEN,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic                         wclk,
    input  logic                         wrst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATASIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATASIZE-1:0]          idata,
    output logic                         wren,
    input  logic                         wr_full,
    output logic [NUM_REQ-1:0]           grant,
    output logic [WR_COUNT_W-1:0]        wr_count
);

    state_t                 state;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          g_idx;
    logic [PW-1:0]          next_ptr;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [NUM_REQ-1:0]     pick;
    logic                   any;
    logic                   valid_g;
    logic                   last_beat;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any)
    );

    // grant is all-zero outside BUSY, so idata falls to 0 when idle
    always_comb begin
        g_idx = '0;
        idata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx = PW'(i);
                idata = req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    assign valid_g   = |(req_valid & grant);
    assign last_beat = (burst_cnt == BURST_CNT_W'(BURST_LEN - 1));
    assign next_ptr  = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

    // reset gates the write path so a burst is abandoned without a final beat
    assign wren      = (state == BUSY) && valid_g && !wr_full && !wrst;
    assign req_ready = wren ? grant : '0;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            wr_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grant     <= pick;
                        burst_cnt <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (wren) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (wr_count != '1) begin
                            wr_count <= wr_count + 1'b1;
                        end
                    end
                    if ((wren && last_beat) || !valid_g) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb/tb_wr_port_arbiter.sv - randomized and directed self-checking bench for wr_port_arbiter
module tb_wr_port_arbiter;

    localparam int N  = 4;
    localparam int BL = 4;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  idata;
    logic        wren;
    logic        wr_full;
    logic [3:0]  grant;
    logic [15:0] wr_count;

    logic        sat_rst = 1'b1;
    logic [1:0]  sat_ready;
    logic [7:0]  sat_idata;
    logic        sat_wren;
    logic [1:0]  sat_grant;
    logic [15:0] sat_count;

    int errors = 0;
    int checks = 0;
    int sat_n  = 0;
    bit armed  = 1'b0;

    int m_cur   = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_wrote = 1'b0;

    logic [3:0] gseq[$];
    logic [7:0] wlog[$];
    logic [3:0] prev_grant = 4'h0;

    wr_port_arbiter u_dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .idata     (idata),
        .wren      (wren),
        .wr_full   (wr_full),
        .grant     (grant),
        .wr_count  (wr_count)
    );

    wr_port_arbiter #(.DATASIZE(8), .NUM_REQ(2), .BURST_LEN(16)) u_sat (
        .wclk      (wclk),
        .wrst      (sat_rst),
        .req_valid (2'b11),
        .req_data  (16'h0000),
        .req_ready (sat_ready),
        .idata     (sat_idata),
        .wren      (sat_wren),
        .wr_full   (1'b0),
        .grant     (sat_grant),
        .wr_count  (sat_count)
    );

    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // always-valid 2-requester, 16-beat bursts: 17 cycles per grant, first one idle
    function automatic int sat_expect(input int n);
        int c;
        c = 16 * (n / 17) + (((n % 17) > 1) ? (n % 17) - 1 : 0);
        return (c > 65535) ? 65535 : c;
    endfunction

    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic f, input logic r);
        logic [3:0] eg, er;
        logic       ew;
        logic [7:0] ed;
        req_valid = v;
        req_data  = d;
        wr_full   = f;
        wrst      = r;
        #1;
        eg = '0; er = '0; ew = 1'b0; ed = '0;
        if (m_cur >= 0) begin
            eg = 4'(1 << m_cur);
            ew = v[m_cur] && !f && !r;
            er = ew ? eg : 4'h0;
            ed = d[m_cur*8 +: 8];
        end
        m_wrote = ew;
        if (armed) begin
            check_eq("grant", 32'(grant), 32'(eg));
            check_eq("wren", 32'(wren), 32'(ew));
            check_eq("req_ready", 32'(req_ready), 32'(er));
            check_eq("idata", 32'(idata), 32'(ed));
            check_eq("wr_count", 32'(wr_count), 32'(m_cnt));
            check_eq("excl", 32'($countones(req_ready) <= 1 && !(wren && wr_full)), 32'd1);
            check_eq("sat_count", 32'(sat_count), 32'(sat_expect(sat_n)));
            check_eq("sat_excl", 32'($countones(sat_ready) <= 1 && $countones(sat_grant) <= 1
                                     && sat_idata == 8'h00 && (sat_wren == (sat_ready != 2'b00))), 32'd1);
        end
        if (grant != 4'h0 && prev_grant == 4'h0) gseq.push_back(grant);
        prev_grant = grant;
        if (wren === 1'b1) wlog.push_back(idata);
        if (r) begin
            m_cur = -1; m_beats = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_cur < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_cur < 0 && v[(m_ptr + k) % N]) m_cur = (m_ptr + k) % N;
            end
            m_beats = 0;
        end else if (ew) begin
            if (m_cnt < 65535) m_cnt++;
            m_beats++;
            if (m_beats == BL) begin
                m_ptr = (m_cur + 1) % N;
                m_cur = -1;
            end
        end else if (!v[m_cur]) begin
            m_ptr = (m_cur + 1) % N;
            m_cur = -1;
        end
        @(posedge wclk);
        if (sat_rst) sat_n = 0;
        else sat_n++;
        armed = 1'b1;
        #1;
    endtask

    initial begin
        int         beat;
        int         cyc;
        logic [7:0] b;
        logic [3:0] v;
        logic [3:0] exp_g[5];

        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

        step(4'h0, 32'h0, 1'b0, 1'b1);
        step(4'h0, 32'h0, 1'b0, 1'b1);
        sat_rst = 1'b0;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_count", 32'(wr_count), 32'h0);

        // single requester, six beats
        wlog.delete();
        beat = 0;
        cyc  = 0;
        while (beat < 6 && cyc < 50) begin
            b = 8'hA0 + 8'(beat);
            step(4'b0010, {16'h0, b, 8'h0}, 1'b0, 1'b0);
            cyc++;
            if (m_wrote) beat++;
        end
        check_eq("req032_cycles", 32'(cyc), 32'd8);
        check_eq("req032_count", 32'(wr_count), 32'd6);
        check_eq("req032_nwrites", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) check_eq("req032_data", 32'(wlog[i]), 32'(8'hA0 + i));
        step(4'h0, 32'h0, 1'b0, 1'b0);

        // all requesters valid: strict rotation
        step(4'h0, 32'h0, 1'b0, 1'b1);
        gseq.delete();
        for (int i = 0; i < 25; i++) step(4'b1111, $urandom, 1'b0, 1'b0);
        check_eq("req033_ngrants", 32'(gseq.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < gseq.size(); i++) check_eq("req033_grant", 32'(gseq[i]), 32'(exp_g[i]));
        check_eq("req033_count", 32'(wr_count), 32'd20);

        // full stall mid-burst
        step(4'h0, 32'h0, 1'b0, 1'b1);
        wlog.delete();
        for (int i = 0; i < 3; i++) step(4'b0001, 32'h11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0001, 32'h22, 1'b1, 1'b0);
        check_eq("req034_hold", 32'(grant), 32'b0001);
        check_eq("req034_stall_cnt", 32'(wr_count), 32'd2);
        for (int i = 0; i < 2; i++) step(4'b0001, 32'h33, 1'b0, 1'b0);
        check_eq("req034_count", 32'(wr_count), 32'd4);
        check_eq("req034_nwrites", 32'(wlog.size()), 32'd4);
        step(4'h0, 32'h0, 1'b0, 1'b0);

        // granted requester drops valid
        step(4'h0, 32'h0, 1'b0, 1'b1);
        step(4'b0011, 32'h5566, 1'b0, 1'b0);
        step(4'b0011, 32'h5566, 1'b0, 1'b0);
        step(4'b0010, 32'h5566, 1'b0, 1'b0);
        check_eq("req035_idle", 32'(grant), 32'h0);
        step(4'b0010, 32'h5566, 1'b0, 1'b0);
        check_eq("req035_grant", 32'(grant), 32'b0010);

        // reset during beat 2 of requester 2
        step(4'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0100, 32'h00770000, 1'b0, 1'b0);
        step(4'b0100, 32'h00770000, 1'b0, 1'b1);
        check_eq("req036_grant", 32'(grant), 32'h0);
        check_eq("req036_count", 32'(wr_count), 32'h0);
        step(4'b1111, 32'h0, 1'b0, 1'b0);
        check_eq("req036_next", 32'(grant), 32'b0001);

        // random traffic while the saturation instance runs past 65535 writes
        while (sat_n < 70000) begin
            v = 4'($urandom);
            if ($urandom_range(3) == 0) v = 4'h0;
            step(v, $urandom, ($urandom_range(3) == 0), ($urandom_range(999) == 0));
        end
        check_eq("sat_final", 32'(sat_count), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
